// File: rtl/sodor_rand_instr_gen.sv
// sodor_rand_instr_gen: seeded LFSR-driven RV32I stimulus stream with NOP preamble, weighted class mix, bounded count and RAW-hazard injection
module sodor_rand_instr_gen #(
  parameter logic [63:0] SEED          = 64'h0000_0000_0000_027B,
  parameter int unsigned NOP_CYCLES    = 3,
  parameter int unsigned INSTR_COUNT   = 100,
  parameter int unsigned W_ALUI        = 8,
  parameter int unsigned W_LOAD        = 8,
  parameter int unsigned W_STORE       = 0,
  parameter int unsigned W_ALUR        = 0,
  parameter logic [2:0]  LOAD_F3_MASK  = 3'b100,
  parameter logic [11:0] LOAD_IMM_MASK = 12'hFFF,
  parameter bit          HAZARD_EN     = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic        seed_load,
  input  logic [63:0] seed_val,
  input  logic        instr_ready,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [2:0]  instr_class,
  output logic [15:0] count,
  output logic        done
);
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [63:0] TAPS     = 64'hD800_0000_0000_0000;
  localparam logic [63:0] SEED_NZ  = (SEED == 64'd0) ? 64'd1 : SEED;
  localparam logic [4:0]  B_ALUI   = 5'(W_ALUI);
  localparam logic [4:0]  B_LOAD   = 5'(W_ALUI + W_LOAD);
  localparam logic [4:0]  B_STORE  = 5'(W_ALUI + W_LOAD + W_STORE);

  typedef enum logic [1:0] {S_NOPS, S_RUN, S_DONE} state_t;

  if (W_ALUI + W_LOAD + W_STORE + W_ALUR != 16) begin : g_bad_weights
    $error("sodor_rand_instr_gen: class weights must sum to 16");
  end

  state_t      state_q, state_d;
  logic [63:0] lfsr_q, lfsr_d, lfsr_adv;
  logic [31:0] instr_q, instr_d, gen_instr;
  logic [2:0]  cls_q, cls_d, gen_cls, f3;
  logic        valid_q, valid_d, done_q, done_d, fire, take, to_nop;
  logic [15:0] count_q, count_d;
  logic [7:0]  nop_cnt_q, nop_cnt_d;
  logic [4:0]  last_rd_q, last_rd_d, rs1, sel;
  logic [11:0] ld_imm;

  // eight unrolled Galois steps of x^64+x^63+x^61+x^60+1
  always_comb begin
    lfsr_adv = lfsr_q;
    for (int i = 0; i < 8; i++) lfsr_adv = lfsr_adv[0] ? ((lfsr_adv >> 1) ^ TAPS) : (lfsr_adv >> 1);
  end

  // sequencing through preamble, random stream and done; seed_load outranks any fire
  always_comb begin
    fire      = valid_q & instr_ready;
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    valid_d   = valid_q;
    count_d   = count_q;
    done_d    = done_q;
    nop_cnt_d = nop_cnt_q;
    last_rd_d = last_rd_q;
    take      = 1'b0;
    to_nop    = 1'b0;
    if (seed_load) begin
      state_d   = S_NOPS;
      lfsr_d    = (seed_val == 64'd0) ? 64'd1 : seed_val;
      valid_d   = 1'b1;
      count_d   = '0;
      done_d    = 1'b0;
      nop_cnt_d = '0;
      last_rd_d = '0;
      to_nop    = 1'b1;
    end else if (state_q == S_NOPS) begin
      if (NOP_CYCLES == 0) begin
        state_d = S_RUN;
        valid_d = 1'b0;
      end else if (!valid_q) begin
        valid_d = 1'b1;
        to_nop  = 1'b1;
      end else if (fire) begin
        nop_cnt_d = nop_cnt_q + 8'd1;
        if ({1'b0, nop_cnt_q} + 9'd1 == 9'(NOP_CYCLES)) begin
          state_d = S_RUN;
          take    = en;
          valid_d = en;
        end
      end
    end else if (state_q == S_RUN) begin
      if (!valid_q) begin
        take    = en;
        valid_d = en;
      end else if (fire) begin
        lfsr_d    = lfsr_adv;
        count_d   = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
        last_rd_d = (cls_q == 3'd2) ? last_rd_q : lfsr_q[26:22];
        if (INSTR_COUNT != 0 && count_d == 16'(INSTR_COUNT)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          valid_d = 1'b1;
          to_nop  = 1'b1;
        end else begin
          take    = en;
          valid_d = en;
        end
      end
    end
  end

  // decode the LFSR state that the next random word is drawn from
  always_comb begin
    f3        = lfsr_d[29:27];
    sel       = {1'b0, lfsr_d[35:32]};
    rs1       = (HAZARD_EN && lfsr_d[40]) ? last_rd_d : lfsr_d[16:12];
    ld_imm    = lfsr_d[11:0] & LOAD_IMM_MASK;
    gen_cls   = (sel < B_ALUI) ? 3'd0 : (sel < B_LOAD) ? 3'd1 : (sel < B_STORE) ? 3'd2 : 3'd3;
    gen_instr = (gen_cls == 3'd0) ? {lfsr_d[11:0] & ((f3 == 3'd5) ? 12'h41F : (f3 == 3'd1) ? 12'h01F : 12'hFFF),
                                     rs1, f3, lfsr_d[26:22], 7'b0010011}
              : (gen_cls == 3'd1) ? {ld_imm, rs1, f3 & LOAD_F3_MASK, lfsr_d[26:22], 7'b0000011}
              : (gen_cls == 3'd2) ? {ld_imm[11:5], lfsr_d[21:17], rs1, 1'b0, (f3[1:0] == 2'd3) ? 2'd2 : f3[1:0],
                                     ld_imm[4:0], 7'b0100011}
              : {1'b0, lfsr_d[30] & (f3 == 3'd0 || f3 == 3'd5), 5'd0, lfsr_d[21:17], rs1, f3, lfsr_d[26:22], 7'b0110011};
  end

  // present a fresh random word, a NOP, or hold the current word
  always_comb begin
    instr_d = take ? gen_instr : to_nop ? NOP : instr_q;
    cls_d   = take ? gen_cls : to_nop ? 3'd4 : cls_q;
  end

  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_NOPS;
      lfsr_q    <= SEED_NZ;
      instr_q   <= NOP;
      cls_q     <= 3'd4;
      valid_q   <= 1'b0;
      count_q   <= '0;
      done_q    <= 1'b0;
      nop_cnt_q <= '0;
      last_rd_q <= '0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      instr_q   <= instr_d;
      cls_q     <= cls_d;
      valid_q   <= valid_d;
      count_q   <= count_d;
      done_q    <= done_d;
      nop_cnt_q <= nop_cnt_d;
      last_rd_q <= last_rd_d;
    end
  end

  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign instr_class = cls_q;
  assign count       = count_q;
  assign done        = done_q;
endmodule

// File: tb/tb_sodor_rand_instr_gen.sv
// tb_sodor_rand_instr_gen: directed self-checking bench for the random instruction generator
module tb_sodor_rand_instr_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, en, seed_load, instr_ready;
  logic [63:0] seed_val;
  logic        instr_valid, done;
  logic [31:0] instr;
  logic [2:0]  instr_class;
  logic [15:0] count;
  logic        v2, d2;
  logic [31:0] i2;
  logic [2:0]  c2;
  logic [15:0] n2;

  int checks = 0;
  int failures = 0;
  logic [63:0] m_lfsr;
  logic [4:0]  m_lrd;

  localparam logic [63:0] SX = 64'hDEAD_BEEF_1234_5678;
  localparam logic [31:0] NOPW = 32'h0000_0013;

  sodor_rand_instr_gen #(
    .NOP_CYCLES(3), .INSTR_COUNT(100), .W_ALUI(4), .W_LOAD(4), .W_STORE(4), .W_ALUR(4),
    .LOAD_F3_MASK(3'b100), .LOAD_IMM_MASK(12'hFF0), .HAZARD_EN(1'b1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .seed_load(seed_load), .seed_val(seed_val),
    .instr_ready(instr_ready), .instr_valid(instr_valid), .instr(instr),
    .instr_class(instr_class), .count(count), .done(done)
  );

  sodor_rand_instr_gen #(
    .NOP_CYCLES(0), .INSTR_COUNT(0), .W_ALUI(16), .W_LOAD(0), .W_STORE(0), .W_ALUR(0)
  ) dut_alui (
    .clk(clk), .reset_n(reset_n), .en(1'b1), .seed_load(1'b0), .seed_val(64'd0),
    .instr_ready(1'b1), .instr_valid(v2), .instr(i2), .instr_class(c2), .count(n2), .done(d2)
  );

  function automatic logic [63:0] m_adv(input logic [63:0] s);
    logic [63:0] r;
    r = s;
    for (int k = 0; k < 8; k++) begin
      if (r[0]) r = {1'b0, r[63:1]} ^ 64'hD800_0000_0000_0000;
      else r = {1'b0, r[63:1]};
    end
    return r;
  endfunction

  function automatic logic [2:0] m_class(input logic [63:0] s);
    return {1'b0, s[35:34]};
  endfunction

  function automatic logic [31:0] m_word(input logic [63:0] s, input logic [4:0] lrd);
    logic [4:0]  r1;
    logic [2:0]  f;
    logic [11:0] im, mi;
    logic [31:0] w;
    r1 = s[40] ? lrd : s[16:12];
    f  = s[29:27];
    im = s[11:0];
    mi = im & 12'hFF0;
    case (s[35:34])
      2'd0: begin
        if (f == 3'd1) im = {7'd0, im[4:0]};
        else if (f == 3'd5) im = {1'b0, im[10], 5'd0, im[4:0]};
        w = {im, r1, f, s[26:22], 7'h13};
      end
      2'd1: w = {mi, r1, f[2], 2'b00, s[26:22], 7'h03};
      2'd2: w = {mi[11:5], s[21:17], r1, 1'b0, (f[1:0] == 2'd3) ? 2'd2 : f[1:0], mi[4:0], 7'h23};
      default: w = {1'b0, s[30] & (f == 3'd0 || f == 3'd5), 5'd0, s[21:17], r1, f, s[26:22], 7'h33};
    endcase
    return w;
  endfunction

  task automatic m_fire();
    if (m_class(m_lfsr) != 3'd2) m_lrd = m_lfsr[26:22];
    m_lfsr = m_adv(m_lfsr);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; en = 1'b0; seed_load = 1'b0; seed_val = '0; instr_ready = 1'b0;
    tick(); tick();
    m_lfsr = 64'h27B; m_lrd = '0;
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
    checks++; if (instr !== NOPW) begin failures++; $display("FAIL reset_instr got=%h exp=%h", instr, NOPW); end
    checks++; if (instr_class !== 3'd4) begin failures++; $display("FAIL reset_class got=%0d exp=4", instr_class); end
    checks++; if (count !== 16'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
  endtask

  task automatic test_preamble();
    int nops = 0;
    int guard = 0;
    reset_n = 1'b1; en = 1'b1; instr_ready = 1'b1;
    while (!(instr_valid && instr_class != 3'd4) && guard < 20) begin
      tick(); guard++;
      if (instr_valid && instr_class == 3'd4) begin
        nops++;
        checks++; if (instr !== NOPW) begin failures++; $display("FAIL preamble_nop got=%h exp=%h", instr, NOPW); end
      end
    end
    checks++; if (nops != 3) begin failures++; $display("FAIL preamble_len got=%0d exp=3", nops); end
    checks++; if (instr !== 32'h27B0_0013) begin failures++; $display("FAIL first_word got=%h exp=27b00013", instr); end
    checks++; if (instr_class !== 3'd0) begin failures++; $display("FAIL first_class got=%0d exp=0", instr_class); end
    tick(); m_fire();
    checks++; if (count !== 16'd1) begin failures++; $display("FAIL first_count got=%0d exp=1", count); end
  endtask

  task automatic test_stall();
    logic [31:0] w;
    logic [2:0]  c;
    logic [15:0] k;
    instr_ready = 1'b0;
    w = instr; c = instr_class; k = count;
    checks++; if (w !== m_word(m_lfsr, m_lrd)) begin failures++; $display("FAIL stall_word got=%h exp=%h", w, m_word(m_lfsr, m_lrd)); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (instr !== w || instr_class !== c || count !== k || instr_valid !== 1'b1) begin
        failures++; $display("FAIL stall_hold got=%h/%0d/%0d exp=%h/%0d/%0d", instr, instr_class, count, w, c, k);
      end
    end
    instr_ready = 1'b1;
    tick(); m_fire();
    checks++; if (count !== k + 16'd1) begin failures++; $display("FAIL stall_accept got=%0d exp=%0d", count, k + 16'd1); end
    checks++; if (instr !== m_word(m_lfsr, m_lrd)) begin failures++; $display("FAIL stall_next got=%h exp=%h", instr, m_word(m_lfsr, m_lrd)); end
  endtask

  task automatic test_en_gating();
    logic [31:0] w;
    logic [15:0] k;
    en = 1'b0; instr_ready = 1'b0; w = instr;
    tick();
    checks++; if (instr_valid !== 1'b1 || instr !== w) begin failures++; $display("FAIL en_drop_hold got=%b/%h exp=1/%h", instr_valid, instr, w); end
    instr_ready = 1'b1; k = count;
    tick(); m_fire();
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL en_idle got=%b exp=0", instr_valid); end
    tick();
    checks++; if (instr_valid !== 1'b0 || count !== k + 16'd1) begin failures++; $display("FAIL en_idle2 got=%b/%0d exp=0/%0d", instr_valid, count, k + 16'd1); end
    en = 1'b1;
    tick();
    checks++; if (instr_valid !== 1'b1 || instr !== m_word(m_lfsr, m_lrd)) begin
      failures++; $display("FAIL en_resume got=%b/%h exp=1/%h", instr_valid, instr, m_word(m_lfsr, m_lrd));
    end
  endtask

  task automatic test_run_to_done();
    int guard = 0;
    while (count < 16'd100 && guard < 400) begin
      if (count == 16'd99) begin
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL done_early got=%b exp=0", done); end
      end
      if (instr_valid && instr_class != 3'd4) begin
        checks++; if (instr !== m_word(m_lfsr, m_lrd)) begin failures++; $display("FAIL run_word got=%h exp=%h", instr, m_word(m_lfsr, m_lrd)); end
        checks++; if (instr_class !== m_class(m_lfsr)) begin failures++; $display("FAIL run_class got=%0d exp=%0d", instr_class, m_class(m_lfsr)); end
        m_fire();
      end
      tick(); guard++;
    end
    checks++; if (done !== 1'b1 || count !== 16'd100) begin failures++; $display("FAIL done_rise got=%b/%0d exp=1/100", done, count); end
    repeat (3) tick();
    checks++; if (done !== 1'b1 || count !== 16'd100 || instr !== NOPW || instr_class !== 3'd4 || instr_valid !== 1'b1) begin
      failures++; $display("FAIL done_hold got=%b/%0d/%h/%0d exp=1/100/%h/4", done, count, instr, instr_class, NOPW);
    end
  endtask

  task automatic test_seed_zero_hazard();
    int got = 0, guard = 0, nops = 0, hz = 0;
    logic prev_ok = 1'b0;
    logic [4:0] prev_rd = '0;
    seed_load = 1'b1; seed_val = 64'd0;
    tick();
    seed_load = 1'b0; m_lfsr = 64'd1; m_lrd = '0;
    checks++; if (instr !== NOPW || instr_valid !== 1'b1 || count !== 16'd0 || done !== 1'b0) begin
      failures++; $display("FAIL seed0_restart got=%h/%b/%0d/%b exp=%h/1/0/0", instr, instr_valid, count, done, NOPW);
    end
    while (got < 80 && guard < 400) begin
      if (instr_valid && instr_class == 3'd4) nops++;
      else if (instr_valid) begin
        if (got == 0) begin
          checks++; if (instr !== 32'h0010_0013) begin failures++; $display("FAIL seed0_first got=%h exp=00100013", instr); end
        end
        if (m_lfsr[40] && prev_ok) begin
          hz++;
          checks++; if (instr[19:15] !== prev_rd) begin failures++; $display("FAIL hazard_rs1 got=%0d exp=%0d", instr[19:15], prev_rd); end
        end
        checks++; if (instr !== m_word(m_lfsr, m_lrd)) begin failures++; $display("FAIL seed0_word got=%h exp=%h", instr, m_word(m_lfsr, m_lrd)); end
        if (instr_class != 3'd2) begin prev_ok = 1'b1; prev_rd = instr[11:7]; end
        m_fire(); got++;
      end
      tick(); guard++;
    end
    checks++; if (got != 80 || nops != 3) begin failures++; $display("FAIL seed0_stream got=%0d/%0d exp=80/3", got, nops); end
    checks++; if (hz == 0) begin failures++; $display("FAIL hazard_seen got=%0d exp>0", hz); end
  endtask

  task automatic test_seed_fire_same_cycle();
    checks++; if (instr_valid !== 1'b1 || instr_class == 3'd4) begin failures++; $display("FAIL sf_pending got=%b/%0d exp=1/random", instr_valid, instr_class); end
    seed_load = 1'b1; seed_val = SX;
    tick();
    seed_load = 1'b0; m_lfsr = SX; m_lrd = '0;
    checks++; if (count !== 16'd0 || instr !== NOPW || instr_class !== 3'd4 || done !== 1'b0) begin
      failures++; $display("FAIL sf_drop got=%0d/%h/%0d/%b exp=0/%h/4/0", count, instr, instr_class, done, NOPW);
    end
  endtask

  task automatic test_repeat();
    logic [31:0] wv[2][20];
    for (int p = 0; p < 2; p++) begin
      int got = 0, guard = 0;
      if (p == 1) begin
        seed_load = 1'b1; seed_val = SX;
        tick();
        seed_load = 1'b0; m_lfsr = SX; m_lrd = '0;
      end
      while (got < 20 && guard < 200) begin
        if (instr_valid && instr_class != 3'd4) begin
          wv[p][got] = instr;
          checks++; if (instr !== m_word(m_lfsr, m_lrd)) begin failures++; $display("FAIL rep_word got=%h exp=%h", instr, m_word(m_lfsr, m_lrd)); end
          m_fire(); got++;
        end
        tick(); guard++;
      end
      checks++; if (got != 20) begin failures++; $display("FAIL rep_timeout got=%0d exp=20", got); end
    end
    for (int i = 0; i < 20; i++) begin
      checks++; if (wv[1][i] !== wv[0][i]) begin failures++; $display("FAIL rep_same[%0d] got=%h exp=%h", i, wv[1][i], wv[0][i]); end
    end
  endtask

  task automatic test_alui_only();
    int seen = 0, bad_op = 0, bad_f1 = 0, bad_f5 = 0, bad_misc = 0;
    logic [15:0] n0;
    n0 = n2;
    for (int i = 0; i < 2000; i++) begin
      if (v2) begin
        seen++;
        if (i2[6:0] != 7'b0010011 || c2 != 3'd0) bad_op++;
        if (i2[14:12] == 3'd1 && i2[31:25] != 7'h00) bad_f1++;
        if (i2[14:12] == 3'd5 && i2[31:25] != 7'h00 && i2[31:25] != 7'h20) bad_f5++;
      end
      if (d2 !== 1'b0) bad_misc++;
      tick();
    end
    checks++; if (bad_op != 0) begin failures++; $display("FAIL alui_opcode got=%0d exp=0", bad_op); end
    checks++; if (bad_f1 != 0) begin failures++; $display("FAIL alui_slli got=%0d exp=0", bad_f1); end
    checks++; if (bad_f5 != 0) begin failures++; $display("FAIL alui_srxi got=%0d exp=0", bad_f5); end
    checks++; if (bad_misc != 0) begin failures++; $display("FAIL alui_done got=%0d exp=0", bad_misc); end
    checks++; if (n2 - n0 !== 16'(seen)) begin failures++; $display("FAIL alui_count got=%0d exp=%0d", n2 - n0, seen); end
  endtask

  task automatic test_reset_midstream();
    int guard = 0;
    reset_n = 1'b0;
    tick();
    checks++; if (instr_valid !== 1'b0 || instr !== NOPW || instr_class !== 3'd4 || count !== 16'd0 || done !== 1'b0) begin
      failures++; $display("FAIL midreset got=%b/%h/%0d/%0d/%b exp=0/%h/4/0/0", instr_valid, instr, instr_class, count, done, NOPW);
    end
    reset_n = 1'b1;
    while (!(instr_valid && instr_class != 3'd4) && guard < 20) begin tick(); guard++; end
    checks++; if (instr !== 32'h27B0_0013) begin failures++; $display("FAIL midreset_first got=%h exp=27b00013", instr); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_preamble();
    test_stall();
    test_en_gating();
    test_run_to_done();
    test_seed_zero_hazard();
    test_seed_fire_same_cycle();
    test_repeat();
    test_alui_only();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
